// File: rtl/timekeeper_param.sv
// rtl/timekeeper_param.sv - prescaled up/down time counter with programmable wrap, load and one-shot alarm
// Optional alarm logic is built only when TIMEKEEPER_ALARM_EN is defined.
module timekeeper_param #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
  parameter int               PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cur_time,
  output logic             tick,
  output logic             wrap,
  input  logic [WIDTH-1:0] alarm_val,
  input  logic             alarm_arm,
  input  logic             alarm_ack,
  output logic             alarm_flag
);
  localparam int              PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PS_ONE  = PW'(1);
  localparam logic [WIDTH:0]  ONE     = (WIDTH + 1)'(1);

  logic [PW-1:0]    presc;
  logic             step;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH-1:0] next_time;
  logic             next_wrap;
  logic [WIDTH-1:0] load_clamped;

  assign step         = en && !load && (presc == PS_LAST);
  assign up_sum       = {1'b0, cur_time} + ONE;
  assign dn_diff      = {1'b0, cur_time} - ONE;
  assign load_clamped = (load_val > MAX_COUNT) ? MAX_COUNT : load_val;

  // One extra bit catches both overshoot past MAX_COUNT and borrow below zero.
  always_comb begin
    next_time = cur_time;
    next_wrap = 1'b0;
    if (dir) begin
      if (dn_diff[WIDTH]) begin
        next_time = MAX_COUNT;
        next_wrap = 1'b1;
      end else begin
        next_time = dn_diff[WIDTH-1:0];
      end
    end else begin
      if (up_sum > {1'b0, MAX_COUNT}) begin
        next_time = '0;
        next_wrap = 1'b1;
      end else begin
        next_time = up_sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_time <= '0;
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        cur_time <= load_clamped;
        presc    <= '0;
      end else if (en) begin
        if (step) begin
          presc    <= '0;
          cur_time <= next_time;
          tick     <= 1'b1;
          wrap     <= next_wrap;
        end else begin
          presc <= presc + PS_ONE;
        end
      end
    end
  end

`ifdef TIMEKEEPER_ALARM_EN
  logic [WIDTH-1:0] cmp;
  logic             armed;
  logic             match;

  assign match = step && armed && (next_time == cmp);

  // A fresh arm on the matching edge survives; a set beats a same-edge ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp        <= '0;
      armed      <= 1'b0;
      alarm_flag <= 1'b0;
    end else begin
      if (match) begin
        alarm_flag <= 1'b1;
      end else if (alarm_ack) begin
        alarm_flag <= 1'b0;
      end
      if (alarm_arm) begin
        cmp   <= alarm_val;
        armed <= 1'b1;
      end else if (match) begin
        armed <= 1'b0;
      end
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_val, alarm_arm, alarm_ack};
  assign alarm_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_param.sv
// tb/tb_timekeeper_param.sv - scoreboard bench for timekeeper_param (WIDTH=8, MAX_COUNT=59, PRESCALE=4)
module tb_timekeeper_param;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] cur_time;
  logic       tick;
  logic       wrap;
  logic [7:0] alarm_val;
  logic       alarm_arm;
  logic       alarm_ack;
  logic       alarm_flag;

  timekeeper_param #(.WIDTH(8), .MAX_COUNT(8'd59), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .cur_time(cur_time), .tick(tick), .wrap(wrap), .alarm_val(alarm_val),
    .alarm_arm(alarm_arm), .alarm_ack(alarm_ack), .alarm_flag(alarm_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int t;
    bit w;
    bit f;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input int t, input bit w, input bit f);
    exp_t e;
    e.cyc = c; e.t = t; e.w = w; e.f = f;
    exp_q.push_back(e);
  endtask

  // Steps from 'start' with prescaler at 0: tick k lands 4*k edges later.
  task automatic run_steps(input int n, input int start, input bit down, input bit flag);
    int v = start;
    en = 1'b1; load = 1'b0; dir = down;
    for (int k = 1; k <= n; k++) begin
      bit w;
      if (down) begin
        w = (v == 0);
        v = w ? 59 : v - 1;
      end else begin
        w = (v == 59);
        v = w ? 0 : v + 1;
      end
      push(cyc + 4 * k, v, w, flag);
    end
    repeat (4 * n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (tick) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_tick", int'(cur_time), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("tick_edge", cyc, e.cyc);
        chk("tick_time", int'(cur_time), e.t);
        chk("tick_wrap", int'(wrap), int'(e.w));
        chk("tick_flag", int'(alarm_flag), int'(e.f));
      end
    end else begin
      chk("wrap_without_tick", int'(wrap), 0);
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_tick_at_edge", cyc, -exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    chk("range_le_max", int'(cur_time <= 8'd59), 1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    alarm_val = '0; alarm_arm = 1'b0; alarm_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_time", int'(cur_time), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_flag", int'(alarm_flag), 0);

    // Count up through 58,59,0(wrap),1,2
    rst_n = 1'b1;
    run_steps(62, 0, 1'b0, 1'b0);
    chk("up_end_time", int'(cur_time), 2);

    // Load 0, then count down: 59 with wrap, then 58
    en = 1'b1; load = 1'b1; load_val = 8'd0;
    @(negedge clk);
    load = 1'b0;
    chk("load0_time", int'(cur_time), 0);
    chk("load0_tick", int'(tick), 0);
    run_steps(2, 0, 1'b1, 1'b0);
    chk("down_time", int'(cur_time), 58);

    // Two enabled edges, freeze 10 edges, resume two edges later
    en = 1'b1; dir = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("frozen_time", int'(cur_time), 58);
    en = 1'b1;
    push(cyc + 2, 57, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("resume_time", int'(cur_time), 57);

    // Clamped load, then load with en=0
    load = 1'b1; load_val = 8'd200;
    @(negedge clk);
    chk("clamp_time", int'(cur_time), 59);
    chk("clamp_tick", int'(tick), 0);
    en = 1'b0; load_val = 8'd7;
    @(negedge clk);
    load = 1'b0;
    chk("load7_time", int'(cur_time), 7);
    run_steps(1, 7, 1'b0, 1'b0);

`ifdef TIMEKEEPER_ALARM_EN
    en = 1'b1; load = 1'b1; load_val = 8'd0; alarm_arm = 1'b1; alarm_val = 8'd10;
    @(negedge clk);
    load = 1'b0; alarm_arm = 1'b0;
    chk("armed_flag0", int'(alarm_flag), 0);
    run_steps(9, 0, 1'b0, 1'b0);
    run_steps(3, 9, 1'b0, 1'b1);
    chk("alarm_sticky", int'(alarm_flag), 1);
    en = 1'b0; alarm_ack = 1'b1;
    @(negedge clk);
    alarm_ack = 1'b0;
    chk("ack_clears", int'(alarm_flag), 0);
    run_steps(60, 12, 1'b0, 1'b0);
    en = 1'b0; alarm_arm = 1'b1; alarm_val = 8'd10;
    @(negedge clk);
    alarm_arm = 1'b0; load = 1'b1; load_val = 8'd10;
    @(negedge clk);
    load = 1'b0;
    chk("load_match_time", int'(cur_time), 10);
    chk("load_no_fire", int'(alarm_flag), 0);
    alarm_arm = 1'b1; alarm_val = 8'd11;
    @(negedge clk);
    alarm_arm = 1'b0;
    en = 1'b1; dir = 1'b0; alarm_ack = 1'b1;
    push(cyc + 4, 11, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    alarm_ack = 1'b0;
    chk("set_beats_ack", int'(alarm_flag), 1);
    run_steps(22, 11, 1'b0, 1'b1);
`else
    run_steps(25, 8, 1'b0, 1'b0);
`endif

    chk("pre_reset_time", int'(cur_time), 33);
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_time", int'(cur_time), 0);
    chk("midrst_tick", int'(tick), 0);
    chk("midrst_wrap", int'(wrap), 0);
    chk("midrst_flag", int'(alarm_flag), 0);
    run_steps(1, 0, 1'b0, 1'b0);

    en = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
